// File: rtl/mnist_image_loader.sv
// Byte-stream image loader: assembles little-endian 16-bit signed pixels
// from a header-framed byte stream into a 1 x ARRAY_A_L buffer and
// announces a completed frame with a one-cycle start_comp pulse.
module mnist_image_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ARRAY_A_L  = 784,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [7:0]                           rx_data,
  input  logic                                 rx_valid,
  input  logic                                 hold,
  output logic signed [DATA_WIDTH-1:0]         input_image [0:0][0:ARRAY_A_L-1],
  output logic                                 image_valid,
  output logic                                 start_comp,
  output logic                                 frame_err,
  output logic [$clog2(ARRAY_A_L+1)-1:0]       pix_cnt
);

  localparam int unsigned CW = $clog2(ARRAY_A_L + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(ARRAY_A_L - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                       r_state;
  logic [7:0]                   r_lo;
  logic [CW-1:0]                r_pix_cnt;
  logic [TW-1:0]                r_to_cnt;
  logic                         r_image_valid;
  logic                         r_start_comp;
  logic                         r_frame_err;
  logic signed [DATA_WIDTH-1:0] r_image [0:0][0:ARRAY_A_L-1];
  logic                         w_wr;

  // Buffer writes happen only when the high byte of a pixel arrives
  always_comb begin
    w_wr = (r_state == HI) && rx_valid;
  end

  // Pixel buffer: cleared on reset, one pixel written per completed byte pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < ARRAY_A_L; r++) begin
        r_image[0][r] <= '0;
      end
    end else if (w_wr) begin
      r_image[0][r_pix_cnt] <= DATA_WIDTH'({rx_data, r_lo});
    end
  end

  // Framing FSM with idle timeout; all status outputs registered here.
  // The timeout fires on the cycle the idle counter would reach TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_lo          <= '0;
      r_pix_cnt     <= '0;
      r_to_cnt      <= '0;
      r_image_valid <= 1'b0;
      r_start_comp  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_start_comp <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_valid && (rx_data == HEADER) && !hold) begin
            r_state       <= LO;
            r_pix_cnt     <= '0;
            r_to_cnt      <= '0;
            r_image_valid <= 1'b0;
          end
        end
        LO: begin
          if (rx_valid) begin
            r_lo     <= rx_data;
            r_to_cnt <= '0;
            r_state  <= HI;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        HI: begin
          if (rx_valid) begin
            r_to_cnt  <= '0;
            r_pix_cnt <= r_pix_cnt + 1'b1;
            r_state   <= (r_pix_cnt == LAST_PIX) ? DONE : LO;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        DONE: begin
          r_image_valid <= 1'b1;
          r_start_comp  <= 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign input_image = r_image;
  assign image_valid = r_image_valid;
  assign start_comp  = r_start_comp;
  assign frame_err   = r_frame_err;
  assign pix_cnt     = r_pix_cnt;

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench for mnist_image_loader: framing, timeout, hold lock,
// back-to-back bytes and asynchronous reset mid-frame.
module tb_mnist_image_loader;

  localparam int unsigned N  = 784;
  localparam int unsigned TO = 300;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              hold;
  logic signed [15:0] input_image [0:0][0:N-1];
  logic              image_valid;
  logic              start_comp;
  logic              frame_err;
  logic [9:0]        pix_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int n_sc    = 0;
  int n_fe    = 0;

  mnist_image_loader #(
    .DATA_WIDTH (16),
    .ARRAY_A_L  (N),
    .HEADER     (8'hA5),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .hold        (hold),
    .input_image (input_image),
    .image_valid (image_valid),
    .start_comp  (start_comp),
    .frame_err   (frame_err),
    .pix_cnt     (pix_cnt)
  );

  always #5 clk = ~clk;

  // Count cycles in which the pulse outputs are high
  always @(negedge clk) begin
    if (start_comp) n_sc++;
    if (frame_err)  n_fe++;
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int p, input int i);
    case (p)
      0:       return 16'(i - 392);
      2:       return 16'(i * 37 + 5);
      default: return 16'(16'hFFFF - i * 3);
    endcase
  endfunction

  function automatic logic [15:0] px(input int i);
    return input_image[0][i];
  endfunction

  // Drives one byte for one cycle after `gap` idle cycles; ends 1ns after the edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pixels(input int p, input int first, input int count, input int gap);
    logic [15:0] v;
    for (int i = first; i < first + count; i++) begin
      v = pix(p, i);
      send_byte(v[7:0], gap);
      send_byte(v[15:8], gap);
    end
  endtask

  task automatic send_frame(input int p, input int gap);
    send_byte(8'hA5, gap);
    send_pixels(p, 0, N, gap);
  endtask

  task automatic chk_buf(input string tag, input int p);
    int nb;
    nb = 0;
    for (int i = 0; i < N; i++) if (px(i) !== pix(p, i)) nb++;
    chk(tag, nb, 0);
  endtask

  initial begin
    int sc0;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    hold     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iv",  image_valid, 0);
    chk("rst_sc",  start_comp,  0);
    chk("rst_fe",  frame_err,   0);
    chk("rst_pc",  pix_cnt,     0);
    chk("rst_b0",  px(0),       0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: full frame, pixel i = i-392, one idle cycle between bytes
    send_frame(0, 1);
    chk("t1_sc_n1", start_comp, 0);
    @(posedge clk); #1;
    chk("t1_sc_n2", start_comp,  1);
    chk("t1_iv",    image_valid, 1);
    @(posedge clk); #1;
    chk("t1_sc_off", start_comp, 0);
    chk("t1_nsc",   n_sc, 1);
    chk("t1_b0",    px(0),   16'hFE78);
    chk("t1_b783",  px(783), 16'h0187);
    chk("t1_b392",  px(392), 16'h0000);
    chk("t1_pc",    pix_cnt, N);
    chk_buf("t1_buf", 0);

    // 2: non-header bytes dropped in IDLE, then header starts a frame
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    chk("t2_pc_drop", pix_cnt, N);
    chk("t2_iv_drop", image_valid, 1);
    send_byte(8'hA5, 1);
    chk("t2_pc_hdr", pix_cnt, 0);
    chk("t2_iv_hdr", image_valid, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    chk("t2_pc_1", pix_cnt, 1);

    // 3: 100 data bytes total, then silence until timeout
    for (int j = 2; j < 100; j++) send_byte(8'(j), 0);
    chk("t3_pc50", pix_cnt, 50);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("t3_fe_early", n_fe, 0);
    @(posedge clk); #1;
    chk("t3_fe",     frame_err, 1);
    @(posedge clk); #1;
    chk("t3_fe_off", frame_err, 0);
    chk("t3_nfe",    n_fe, 1);
    chk("t3_iv",     image_valid, 0);
    chk("t3_b0",     px(0),  16'h0100);
    chk("t3_b49",    px(49), 16'h6362);
    chk("t3_b50",    px(50), 16'hFEAA);
    repeat (TO + 5) @(posedge clk);
    chk("t3_nfe2",   n_fe, 1);

    // 5: back-to-back bytes for a complete frame
    sc0 = n_sc;
    send_frame(2, 0);
    repeat (3) @(posedge clk); #1;
    chk("t5_nsc",  n_sc - sc0, 1);
    chk("t5_iv",   image_valid, 1);
    chk("t5_b783", px(783), 16'h7130);
    chk_buf("t5_buf", 2);

    // 4: hold locks the buffer; release and resend is accepted
    hold = 1'b1;
    sc0  = n_sc;
    send_frame(3, 1);
    repeat (3) @(posedge clk); #1;
    chk("t4_hold_nsc", n_sc - sc0, 0);
    chk("t4_hold_iv",  image_valid, 1);
    chk("t4_hold_pc",  pix_cnt, N);
    chk_buf("t4_hold_buf", 2);
    hold = 1'b0;
    send_frame(3, 1);
    repeat (3) @(posedge clk); #1;
    chk("t4_nsc",  n_sc - sc0, 1);
    chk("t4_iv",   image_valid, 1);
    chk("t4_b0",   px(0),   16'hFFFF);
    chk("t4_b783", px(783), 16'hF6D2);
    chk_buf("t4_buf", 3);

    // 6: asynchronous reset at pixel 400
    send_byte(8'hA5, 1);
    send_pixels(0, 0, 400, 1);
    chk("t6_pc400", pix_cnt, 400);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_pc",   pix_cnt,     0);
    chk("t6_iv",   image_valid, 0);
    chk("t6_sc",   start_comp,  0);
    chk("t6_b0",   px(0),       0);
    chk("t6_b399", px(399),     0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk);
    sc0 = n_sc;
    send_frame(2, 1);
    repeat (3) @(posedge clk); #1;
    chk("t6_nsc", n_sc - sc0, 1);
    chk("t6_iv2", image_valid, 1);
    chk_buf("t6_buf", 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
